demux4_byte_collector: RTL and testbench



---
 rtl/demux_pkg.sv | 17 +
 rtl/chan_collector.sv | 58 +++++
 rtl/demux4_byte_collector.sv | 107 ++++++++++
 tb/tb_demux4_byte_collector.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and types for the demux byte collector.
// Channel count and index width are fixed by the 4-way demux upstream.
package demux_pkg;

   localparam int N_CH      = 4;
   localparam int CH_W      = 2;
   localparam int DEF_WIDTH = 8;

   typedef logic [CH_W-1:0] ch_t;

   // OPEN: grant follows the round-robin search; LOCKED: grant frozen until accepted
   typedef enum logic {
      ARB_OPEN   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/chan_collector.sv
// One channel's MSB-first word assembler with a single-entry holding register.
// Emits a one-cycle overflow pulse when a completed word has to be dropped.
module chan_collector #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cap,
   input  logic             bit_in,
   input  logic             pop,
   output logic [WIDTH-1:0] hold,
   output logic             hold_full,
   output logic             ovf_pulse
);

   localparam int              CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] shreg_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [WIDTH-1:0] hold_reg;
   logic             hold_full_reg;
   logic [WIDTH-1:0] new_word;
   logic             word_done;
   logic             load_hold;

   always_comb begin
      new_word  = {shreg_reg[WIDTH-2:0], bit_in};
      word_done = cap && (cnt_reg == CNT_LAST);
      // a pop on the same edge frees the slot, so the new word still fits
      load_hold = word_done && (!hold_full_reg || pop);
      ovf_pulse = word_done && hold_full_reg && !pop;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg_reg     <= '0;
         cnt_reg       <= '0;
         hold_reg      <= '0;
         hold_full_reg <= 1'b0;
      end else begin
         if (cap) begin
            shreg_reg <= new_word;
            cnt_reg   <= word_done ? '0 : cnt_reg + CNT_W'(1);
         end
         if (load_hold) begin
            hold_reg      <= new_word;
            hold_full_reg <= 1'b1;
         end else if (pop) begin
            hold_full_reg <= 1'b0;
         end
      end
   end

   assign hold      = hold_reg;
   assign hold_full = hold_full_reg;

endmodule

// File: rtl/demux4_byte_collector.sv
// Collects serial bits from the 4 demux lines into per-channel words and
// hands them out one at a time through a locking round-robin arbiter.
module demux4_byte_collector
   import demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_valid,
   input  logic [1:0]       sel,
   input  logic [3:0]       dmx_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_chan,
   output logic [3:0]       overflow,
   input  logic             clr_ovf
);

   logic [N_CH-1:0]  cap;
   logic [N_CH-1:0]  pop;
   logic [N_CH-1:0]  full;
   logic [N_CH-1:0]  ovf_pulse;
   logic [WIDTH-1:0] hold_arr [N_CH];
   logic             bit_sel;

   arb_state_t       state_reg, state_next;
   ch_t              rr_ptr_reg, rr_ptr_next;
   ch_t              gnt_reg;
   ch_t              search_gnt;
   ch_t              grant;
   ch_t              idx;
   logic             found;
   logic [N_CH-1:0]  ovf_reg, ovf_next;

   assign bit_sel = dmx_out[sel];

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
         assign cap[gi] = bit_valid && (sel == ch_t'(gi));
         assign pop[gi] = out_valid && out_ready && (grant == ch_t'(gi));

         chan_collector #(.WIDTH(WIDTH)) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .cap       (cap[gi]),
            .bit_in    (bit_sel),
            .pop       (pop[gi]),
            .hold      (hold_arr[gi]),
            .hold_full (full[gi]),
            .ovf_pulse (ovf_pulse[gi])
         );
      end
   endgenerate

   always_comb begin
      search_gnt = rr_ptr_reg;
      found      = 1'b0;
      idx        = '0;
      for (int i = 0; i < N_CH; i++) begin
         idx = rr_ptr_reg + ch_t'(i);
         if (!found && full[idx]) begin
            found      = 1'b1;
            search_gnt = idx;
         end
      end
   end

   // Outputs depend only on registered state, never on out_ready.
   always_comb begin
      grant     = (state_reg == ARB_LOCKED) ? gnt_reg : search_gnt;
      out_valid = full[grant];
      out_data  = out_valid ? hold_arr[grant] : '0;
      out_chan  = out_valid ? grant : '0;
   end

   always_comb begin
      state_next  = state_reg;
      rr_ptr_next = rr_ptr_reg;
      if (out_valid && out_ready) begin
         state_next  = ARB_OPEN;
         rr_ptr_next = grant + ch_t'(1);
      end else if (out_valid) begin
         state_next  = ARB_LOCKED;
      end
      // a fresh overflow beats a simultaneous clear
      ovf_next = (clr_ovf ? '0 : ovf_reg) | ovf_pulse;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= ARB_OPEN;
         rr_ptr_reg <= '0;
         gnt_reg    <= '0;
         ovf_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         rr_ptr_reg <= rr_ptr_next;
         gnt_reg    <= grant;
         ovf_reg    <= ovf_next;
      end
   end

   assign overflow = ovf_reg;

endmodule

// File: tb/tb_demux4_byte_collector.sv
// Directed bench for demux4_byte_collector: stimulus pushes expected words
// into a queue, a negedge monitor pops and compares each accepted word.
module tb_demux4_byte_collector;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         bit_valid;
   logic [1:0]   sel;
   logic [3:0]   dmx_out;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic [1:0]   out_chan;
   logic [3:0]   overflow;
   logic         clr_ovf;

   int           checks   = 0;
   int           failures = 0;
   logic [9:0]   exp_q[$];
   logic [9:0]   mon_e;

   always #5 clk = ~clk;

   demux4_byte_collector #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bit_valid (bit_valid),
      .sel       (sel),
      .dmx_out   (dmx_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // accepted words are compared against the scoreboard in issue order
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word: got chan=%0d data=%0h required no word", out_chan, out_data);
         end else begin
            mon_e = exp_q.pop_front();
            $display("xfer chan=%0d data=%0h (expected chan=%0d data=%0h)",
                     out_chan, out_data, mon_e[9:8], mon_e[7:0]);
            check("xfer_chan", 32'(out_chan), 32'(mon_e[9:8]));
            check("xfer_data", 32'(out_data), 32'(mon_e[7:0]));
         end
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic [1:0] ch, input logic b);
      sel        = ch;
      dmx_out    = 4'($urandom);
      dmx_out[ch] = b;
      bit_valid  = 1'b1;
      sync();
      bit_valid  = 1'b0;
   endtask

   task automatic send_word(input logic [1:0] ch, input logic [7:0] w, input int nbits);
      for (int i = 7; i >= 8 - nbits; i--) drive_bit(ch, w[i]);
   endtask

   task automatic push(input logic [1:0] ch, input logic [7:0] w);
      exp_q.push_back({ch, w});
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         sync();
         n++;
      end
      check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_out_data"},  32'(out_data),  32'd0);
      check({tag, "_out_chan"},  32'(out_chan),  32'd0);
      check({tag, "_overflow"},  32'(overflow),  32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] w0;
      logic [7:0] w1;

      rst_n     = 1'b0;
      bit_valid = 1'b0;
      sel       = 2'd0;
      dmx_out   = 4'h0;
      out_ready = 1'b1;
      clr_ovf   = 1'b0;
      repeat (3) sync();
      @(negedge clk);
      check_idle_outputs("reset");
      sync();
      rst_n = 1'b1;

      // 1: partial word discarded by a 2-cycle reset with bit_valid active
      send_word(2'd1, 8'hFF, 5);
      rst_n     = 1'b0;
      sel       = 2'd1;
      dmx_out   = 4'hF;
      bit_valid = 1'b1;
      sync();
      @(negedge clk);
      check_idle_outputs("midreset");
      sync();
      rst_n     = 1'b0;
      rst_n     = 1'b1;
      bit_valid = 1'b0;
      push(2'd1, 8'h5A);
      send_word(2'd1, 8'h5A, 8);
      drain();

      // 2: single word on ch2, valid for exactly one cycle after the last bit
      push(2'd2, 8'hA5);
      send_word(2'd2, 8'hA5, 8);
      @(negedge clk);
      check("t2_valid_after_last_bit", 32'(out_valid), 32'd1);
      @(negedge clk);
      check("t2_valid_one_cycle", 32'(out_valid), 32'd0);
      sync();
      drain();

      // 3: interleaved ch0/ch1
      w0 = 8'h3C;
      w1 = 8'hC3;
      push(2'd0, w0);
      push(2'd1, w1);
      for (int i = 7; i >= 0; i--) begin
         drive_bit(2'd0, w0[i]);
         drive_bit(2'd1, w1[i]);
      end
      drain();
      check("t3_overflow", 32'(overflow), 32'd0);

      // 4: backpressure, second word on ch3 dropped
      out_ready = 1'b0;
      push(2'd3, 8'h11);
      send_word(2'd3, 8'h11, 8);
      send_word(2'd3, 8'h22, 8);
      @(negedge clk);
      check("t4_overflow_set", 32'(overflow), 32'h8);
      check("t4_valid_held", 32'(out_valid), 32'd1);
      check("t4_chan_held", 32'(out_chan), 32'd3);
      check("t4_data_held", 32'(out_data), 32'h11);
      sync();
      out_ready = 1'b1;
      drain();
      repeat (3) sync();
      @(negedge clk);
      check("t4_no_second_word", 32'(out_valid), 32'd0);
      check("t4_overflow_sticky", 32'(overflow), 32'h8);
      sync();
      clr_ovf = 1'b1;
      sync();
      clr_ovf = 1'b0;
      @(negedge clk);
      check("t4_overflow_cleared", 32'(overflow), 32'd0);
      sync();

      // 5a: all four channels full, drained in order 0,1,2,3
      out_ready = 1'b0;
      push(2'd0, 8'h10);
      push(2'd1, 8'h21);
      push(2'd2, 8'h32);
      push(2'd3, 8'h43);
      send_word(2'd0, 8'h10, 8);
      send_word(2'd1, 8'h21, 8);
      send_word(2'd2, 8'h32, 8);
      send_word(2'd3, 8'h43, 8);
      out_ready = 1'b1;
      drain();

      // 5b/6: ch0 popped while its next word completes; ch2 then wins over ch0
      out_ready = 1'b0;
      push(2'd0, 8'h81);
      push(2'd2, 8'h42);
      push(2'd0, 8'h18);
      send_word(2'd0, 8'h81, 8);
      send_word(2'd2, 8'h42, 8);
      send_word(2'd0, 8'h18, 7);
      out_ready = 1'b1;
      drive_bit(2'd0, 1'b0);
      drain();
      @(negedge clk);
      check("t6_overflow", 32'(overflow), 32'd0);
      check("t6_idle_after", 32'(out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
